game_ctrl: RTL
==============

// Module: game_ctrl
// PURPOSE
//  Match sequencer and paddle-drive scheduler for the Pong top level. Runs the
//  IDLE/SERVE/PLAY/POINT/OVER flow and keeps both scores. Converts held player
//  buttons, or the built-in tracker for paddle 2, into timed up/down strobes.
//  Those strobes feed the two bar instances, which move 1 px per PixelClock
//  cycle while up/down is high. Also drives the bar reset and the ball
//  reset/enable.
// PARAMETERS
//  WinScore    9   points that end a match (1..15)
//  ServeFrames 60  frameTick count spent in SERVE and in POINT (1..255)
//  MoveStep    4   px per paddle move = strobe length in cycles (1..15)
//  MovePeriod  1   frameTicks between paddle moves (1..15)
//  AiDeadband  8   tracker dead zone around paddle-2 centre, px
// PORTS
//  PixelClock  in   1   sole clock, all state on rising edge
//  Reset       in   1   asynchronous, active-low (0 = reset)
//  frameTick   in   1   one-cycle pulse per frame (start of vblank)
//  start       in   1   one-cycle start/restart pulse
//  up1,down1   in   1   player-1 buttons, level, pre-synchronised
//  up2,down2   in   1   player-2 buttons, level, pre-synchronised
//  aiEn        in   1   1 = paddle 2 driven by tracker, buttons ignored
//  ballY       in   11  ball centre y
//  bar2Top     in   11  paddle-2 top
//  bar2Bottom  in   11  paddle-2 bottom
//  missL,missR in   1   one-cycle pulse: ball passed left/right edge
//  barUp1,barDown1  out 1  paddle-1 move strobes
//  barUp2,barDown2  out 1  paddle-2 move strobes
//  barReset    out  1   holds both bars at home position
//  ballReset   out  1   holds ball at serve position
//  ballEnable  out  1   ball motion allowed
//  scoreL,scoreR out 4  scores
//  gameOver    out  1   match finished
//  state       out  3   IDLE=0 SERVE=1 PLAY=2 POINT=3 OVER=4
// BEHAVIOUR
//  - Reset=0: state=IDLE; scores=0; all strobes=0; barReset=1; ballReset=1;
//    ballEnable=0; gameOver=0; frame, phase and strobe counters=0.
//  - All outputs are registered.
//  - IDLE: barReset=1, ballReset=1. start -> SERVE with scores cleared.
//  - SERVE: barReset=0, ballReset=1. Counts ServeFrames frameTicks, then -> PLAY.
//  - PLAY: ballReset=0, ballEnable=1.
//    - missL -> scoreR+1; missR -> scoreL+1.
//    - missL and missR in the same cycle: no score change, -> POINT.
//    - If the new score == WinScore: -> OVER, else -> POINT.
//  - POINT: ballEnable=0, ballReset=1. Waits ServeFrames frameTicks, -> SERVE.
//  - OVER: gameOver=1, ballEnable=0, ballReset=1, no strobes.
//    start -> SERVE with scores cleared and gameOver=0.
//  - start is ignored in SERVE/PLAY/POINT. miss pulses outside PLAY are ignored.
//  - Frame counter clears on every state entry.
//    SERVE/POINT exit on the cycle after the ServeFrames-th tick.
//  - Scheduling:
//    - A phase counter counts frameTicks in SERVE/PLAY/POINT; at MovePeriod it
//      wraps and opens a move window.
//    - Requests are sampled on the window tick.
//    - The strobe rises 1 cycle after that frameTick and stays high for exactly
//      MoveStep cycles.
//    - A request with up and down both high, or with neither high, gives no strobe.
//    - Buttons released mid-window do not shorten the strobe.
//    - A state change out of SERVE/PLAY/POINT kills the strobe next cycle.
//  - Tracker (aiEn=1): centre = (bar2Top + bar2Bottom) >> 1, 12-bit sum.
//    - ballY + AiDeadband < centre -> up request.
//    - ballY > centre + AiDeadband -> down request.
//    - Otherwise none. All compares unsigned 12-bit, no wrap.
//  - aiEn is sampled only on window ticks.
//  - Scores never exceed WinScore; no wrap.
//  - Reset asserted mid-strobe: strobes drop asynchronously.
// TESTING
//  - Reset then start -> state 0->1; barReset=0; ballReset=1. After 60 ticks
//    state=2, ballEnable=1.
//  - PLAY, missL -> scoreR=1, state=3; after 60 ticks -> SERVE.
//    Simultaneous missL+missR -> scores unchanged, state=3.
//  - scoreL=8, missR -> scoreL=9, state=4, gameOver=1, strobes 0.
//    start -> scores 0, state=1.
//  - up1 held, MoveStep=4, MovePeriod=1 -> barUp1 high 4 cycles starting
//    1 cycle after each frameTick. up1+down1 held -> no strobe.
//  - aiEn=1, bar2 240..390 (centre 315), ballY=100 -> barUp2 strobes;
//    ballY=320 -> none; ballY=400 -> barDown2.
//  - Reset low mid-strobe in PLAY -> strobes 0 immediately, state=0, scores 0.

Source files
------------

// File: rtl/game_ctrl.sv
// game_ctrl: match sequencer and paddle-drive scheduler for the Pong top level.
//
// Runs the IDLE -> SERVE -> PLAY -> POINT/OVER flow and keeps both scores.
// Turns held buttons (or the paddle-2 tracker) into fixed-length up/down strobes
// that start one cycle after a move-window frameTick. Also drives bar/ball control.
//
// Ports
//   PixelClock            sole clock, rising edge
//   Reset                 asynchronous, active-low
//   frameTick             one-cycle pulse per frame
//   start                 one-cycle start/restart pulse
//   up1/down1, up2/down2  player buttons (level, already synchronised)
//   aiEn                  1 = paddle 2 follows the tracker, buttons ignored
//   ballY                 ball centre y
//   bar2Top/bar2Bottom    paddle-2 extent
//   missL/missR           one-cycle pulse when the ball passes an edge
//   barUp1/barDown1,
//   barUp2/barDown2       paddle move strobes
//   barReset              holds both bars at home
//   ballReset             holds ball at serve position
//   ballEnable            ball motion allowed
//   scoreL/scoreR         scores
//   gameOver              match finished
//   state                 IDLE=0 SERVE=1 PLAY=2 POINT=3 OVER=4
// All outputs are registered.

module game_ctrl #(
    parameter int unsigned WinScore    = 9,
    parameter int unsigned ServeFrames = 60,
    parameter int unsigned MoveStep    = 4,
    parameter int unsigned MovePeriod  = 1,
    parameter int unsigned AiDeadband  = 8
) (
    input  logic        PixelClock,
    input  logic        Reset,
    input  logic        frameTick,
    input  logic        start,
    input  logic        up1,
    input  logic        down1,
    input  logic        up2,
    input  logic        down2,
    input  logic        aiEn,
    input  logic [10:0] ballY,
    input  logic [10:0] bar2Top,
    input  logic [10:0] bar2Bottom,
    input  logic        missL,
    input  logic        missR,
    output logic        barUp1,
    output logic        barDown1,
    output logic        barUp2,
    output logic        barDown2,
    output logic        barReset,
    output logic        ballReset,
    output logic        ballEnable,
    output logic [3:0]  scoreL,
    output logic [3:0]  scoreR,
    output logic        gameOver,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StServe = 3'd1,
        StPlay  = 3'd2,
        StPoint = 3'd3,
        StOver  = 3'd4
    } state_e;

    localparam logic [3:0]  WinVal     = 4'(WinScore);
    localparam logic [7:0]  ServeLast  = 8'(ServeFrames - 1);
    localparam logic [3:0]  StepLast   = 4'(MoveStep - 1);
    localparam logic [3:0]  PhaseLast  = 4'(MovePeriod - 1);
    localparam logic [11:0] Deadband   = 12'(AiDeadband);

    state_e      state_q, state_d;
    logic [3:0]  score_l_q, score_l_d;
    logic [3:0]  score_r_q, score_r_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [3:0]  phase_q, phase_d;
    logic [3:0]  strobe_cnt_q, strobe_cnt_d;
    logic        up1_q, up1_d, down1_q, down1_d;
    logic        up2_q, up2_d, down2_q, down2_d;
    logic        bar_reset_q, bar_reset_d;
    logic        ball_reset_q, ball_reset_d;
    logic        ball_enable_q, ball_enable_d;
    logic        game_over_q, game_over_d;

    function automatic logic is_active(input state_e s);
        return (s == StServe) || (s == StPlay) || (s == StPoint);
    endfunction

    // Tracker: all arithmetic 12 bits wide so nothing wraps.
    logic [11:0] bar2_sum, centre, ball_ext, ball_plus_db, centre_plus_db;
    logic        ai_up, ai_down;
    logic        req_up1, req_down1, req_up2, req_down2;
    logic        window;

    always_comb begin
        bar2_sum       = {1'b0, bar2Top} + {1'b0, bar2Bottom};
        centre         = {1'b0, bar2_sum[11:1]};
        ball_ext       = {1'b0, ballY};
        ball_plus_db   = ball_ext + Deadband;
        centre_plus_db = centre + Deadband;
        ai_up          = ball_plus_db < centre;
        ai_down        = ball_ext > centre_plus_db;

        // Both or neither button pressed means no move.
        req_up1   = up1 & ~down1;
        req_down1 = down1 & ~up1;
        req_up2   = aiEn ? ai_up   : (up2 & ~down2);
        req_down2 = aiEn ? ai_down : (down2 & ~up2);
    end

    assign window = frameTick && is_active(state_q) && (phase_q == PhaseLast);

    // Match flow and scores.
    always_comb begin
        state_d   = state_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StServe;
                    score_l_d = 4'd0;
                    score_r_d = 4'd0;
                end
            end
            StServe: begin
                if (frameTick && (frame_cnt_q == ServeLast)) state_d = StPlay;
            end
            StPlay: begin
                if (missL && missR) begin
                    state_d = StPoint;
                end else if (missL) begin
                    if (score_r_q < WinVal) score_r_d = score_r_q + 4'd1;
                    state_d = (score_r_q + 4'd1 == WinVal) ? StOver : StPoint;
                end else if (missR) begin
                    if (score_l_q < WinVal) score_l_d = score_l_q + 4'd1;
                    state_d = (score_l_q + 4'd1 == WinVal) ? StOver : StPoint;
                end
            end
            StPoint: begin
                if (frameTick && (frame_cnt_q == ServeLast)) state_d = StServe;
            end
            StOver: begin
                if (start) begin
                    state_d   = StServe;
                    score_l_d = 4'd0;
                    score_r_d = 4'd0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Frame, phase and strobe counters.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (state_d != state_q) begin
            frame_cnt_d = 8'd0;
        end else if (frameTick && ((state_q == StServe) || (state_q == StPoint))) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end

        phase_d = phase_q;
        if (!is_active(state_q)) begin
            phase_d = 4'd0;
        end else if (frameTick) begin
            phase_d = (phase_q == PhaseLast) ? 4'd0 : phase_q + 4'd1;
        end

        strobe_cnt_d = strobe_cnt_q;
        up1_d        = up1_q;
        down1_d      = down1_q;
        up2_d        = up2_q;
        down2_d      = down2_q;
        if (!is_active(state_d)) begin
            // Leaving the active states kills any strobe in flight.
            strobe_cnt_d = 4'd0;
            up1_d        = 1'b0;
            down1_d      = 1'b0;
            up2_d        = 1'b0;
            down2_d      = 1'b0;
        end else if (window) begin
            // Requests are latched here; later button changes do not matter.
            strobe_cnt_d = StepLast;
            up1_d        = req_up1;
            down1_d      = req_down1;
            up2_d        = req_up2;
            down2_d      = req_down2;
        end else if (strobe_cnt_q != 4'd0) begin
            strobe_cnt_d = strobe_cnt_q - 4'd1;
        end else begin
            up1_d   = 1'b0;
            down1_d = 1'b0;
            up2_d   = 1'b0;
            down2_d = 1'b0;
        end
    end

    // Control outputs follow the next state so they line up with the state output.
    always_comb begin
        bar_reset_d   = (state_d == StIdle);
        ball_reset_d  = (state_d != StPlay);
        ball_enable_d = (state_d == StPlay);
        game_over_d   = (state_d == StOver);
    end

    always_ff @(posedge PixelClock or negedge Reset) begin
        if (!Reset) begin
            state_q       <= StIdle;
            score_l_q     <= 4'd0;
            score_r_q     <= 4'd0;
            frame_cnt_q   <= 8'd0;
            phase_q       <= 4'd0;
            strobe_cnt_q  <= 4'd0;
            up1_q         <= 1'b0;
            down1_q       <= 1'b0;
            up2_q         <= 1'b0;
            down2_q       <= 1'b0;
            bar_reset_q   <= 1'b1;
            ball_reset_q  <= 1'b1;
            ball_enable_q <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            score_l_q     <= score_l_d;
            score_r_q     <= score_r_d;
            frame_cnt_q   <= frame_cnt_d;
            phase_q       <= phase_d;
            strobe_cnt_q  <= strobe_cnt_d;
            up1_q         <= up1_d;
            down1_q       <= down1_d;
            up2_q         <= up2_d;
            down2_q       <= down2_d;
            bar_reset_q   <= bar_reset_d;
            ball_reset_q  <= ball_reset_d;
            ball_enable_q <= ball_enable_d;
            game_over_q   <= game_over_d;
        end
    end

    assign barUp1     = up1_q;
    assign barDown1   = down1_q;
    assign barUp2     = up2_q;
    assign barDown2   = down2_q;
    assign barReset   = bar_reset_q;
    assign ballReset  = ball_reset_q;
    assign ballEnable = ball_enable_q;
    assign scoreL     = score_l_q;
    assign scoreR     = score_r_q;
    assign gameOver   = game_over_q;
    assign state      = state_q;

endmodule
